// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding valid/ready command to two-slave APB requester
//
// Purpose:
//   Accepts one command at a time, decodes cmd_addr MSB into PSEL1 (MSB=0) or
//   PSEL2 (MSB=1), runs one SETUP cycle and an ACCESS phase that lasts until the
//   selected slave raises PREADY, then pulses rsp_valid for one cycle.
//   Every output is driven straight from a register.
//
// Optional feature:
//   APB_TIMEOUT_EN - when defined, an ACCESS phase that sees TIMEOUT cycles of
//   selected PREADY low ends as a completion with rsp_err = 1 and rsp_rdata = 0.
//   When undefined, ACCESS waits indefinitely and rsp_err stays 0.
//
// Ports:
//   PCLK, PRESETn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write, cmd_addr            direction; {slave select, PADDR}
//   cmd_wdata, cmd_strb            write data and byte strobes
//   rsp_valid, rsp_rdata, rsp_err  one-cycle completion pulse with held data/error
//   PSEL1, PSEL2, PENABLE, PWRITE  APB control
//   PADDR, PWDATA, PSTRB           APB address/data
//   PREADY1/2, PRDATA1/2           per-slave ready and read data

module apb_master_bridge #(
    parameter int ADDWIDTH  = 8,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDWIDTH:0]      cmd_addr,
    input  logic [DATAWIDTH-1:0]   cmd_wdata,
    input  logic [DATAWIDTH/8-1:0] cmd_strb,
    output logic                   rsp_valid,
    output logic [DATAWIDTH-1:0]   rsp_rdata,
    output logic                   rsp_err,
    output logic                   PSEL1,
    output logic                   PSEL2,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [ADDWIDTH-1:0]    PADDR,
    output logic [DATAWIDTH-1:0]   PWDATA,
    output logic [DATAWIDTH/8-1:0] PSTRB,
    input  logic                   PREADY1,
    input  logic                   PREADY2,
    input  logic [DATAWIDTH-1:0]   PRDATA1,
    input  logic [DATAWIDTH-1:0]   PRDATA2
);

    localparam int STRBW = DATAWIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                 state_q, state_n;
    logic                   cmd_ready_q, cmd_ready_n;
    logic                   rsp_valid_q, rsp_valid_n;
    logic [DATAWIDTH-1:0]   rsp_rdata_q, rsp_rdata_n;
    logic                   rsp_err_q, rsp_err_n;
    logic                   psel1_q, psel1_n;
    logic                   psel2_q, psel2_n;
    logic                   penable_q, penable_n;
    logic                   pwrite_q, pwrite_n;
    logic [ADDWIDTH-1:0]    paddr_q, paddr_n;
    logic [DATAWIDTH-1:0]   pwdata_q, pwdata_n;
    logic [STRBW-1:0]       pstrb_q, pstrb_n;

    // Only the addressed slave's handshake is looked at; the other slave may
    // drive anything on its PREADY/PRDATA.
    logic                   sel_ready;
    logic [DATAWIDTH-1:0]   sel_rdata;

    assign sel_ready = psel2_q ? PREADY2 : PREADY1;
    assign sel_rdata = psel2_q ? PRDATA2 : PRDATA1;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt_q, to_cnt_n;
`endif

    always_comb begin
        state_n     = state_q;
        cmd_ready_n = cmd_ready_q;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata_q;
        rsp_err_n   = rsp_err_q;
        psel1_n     = psel1_q;
        psel2_n     = psel2_q;
        penable_n   = penable_q;
        pwrite_n    = pwrite_q;
        paddr_n     = paddr_q;
        pwdata_n    = pwdata_q;
        pstrb_n     = pstrb_q;
`ifdef APB_TIMEOUT_EN
        to_cnt_n    = to_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                // cmd_ready rises on the first edge after reset release.
                cmd_ready_n = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    state_n     = SETUP;
                    cmd_ready_n = 1'b0;
                    psel1_n     = ~cmd_addr[ADDWIDTH];
                    psel2_n     = cmd_addr[ADDWIDTH];
                    pwrite_n    = cmd_write;
                    paddr_n     = cmd_addr[ADDWIDTH-1:0];
                    pwdata_n    = cmd_wdata;
                    pstrb_n     = cmd_write ? cmd_strb : '0;
                end
            end

            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
`ifdef APB_TIMEOUT_EN
                to_cnt_n  = '0;
`endif
            end

            ACCESS: begin
                // PREADY is checked first so that it wins over a coincident timeout.
                if (sel_ready) begin
                    state_n     = IDLE;
                    cmd_ready_n = 1'b1;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = pwrite_q ? '0 : sel_rdata;
                    rsp_err_n   = 1'b0;
                    psel1_n     = 1'b0;
                    psel2_n     = 1'b0;
                    penable_n   = 1'b0;
                end
`ifdef APB_TIMEOUT_EN
                // The counter holds the number of not-ready cycles already seen,
                // so TIMEOUT-1 here means this is the TIMEOUT-th one.
                else if (to_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_n     = IDLE;
                    cmd_ready_n = 1'b1;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = '0;
                    rsp_err_n   = 1'b1;
                    psel1_n     = 1'b0;
                    psel2_n     = 1'b0;
                    penable_n   = 1'b0;
                end else begin
                    to_cnt_n = to_cnt_q + CNT_W'(1);
                end
`endif
            end

            default: begin
                state_n     = IDLE;
                cmd_ready_n = 1'b0;
                psel1_n     = 1'b0;
                psel2_n     = 1'b0;
                penable_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
        end else begin
            state_q     <= state_n;
            cmd_ready_q <= cmd_ready_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
            rsp_err_q   <= rsp_err_n;
            psel1_q     <= psel1_n;
            psel2_q     <= psel2_n;
            penable_q   <= penable_n;
            pwrite_q    <= pwrite_n;
            paddr_q     <= paddr_n;
            pwdata_q    <= pwdata_n;
            pstrb_q     <= pstrb_n;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_n;
        end
    end
`endif

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL1     = psel1_q;
    assign PSEL2     = psel2_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge

module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [8:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL1, PSEL2, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY1, PREADY2;
    logic [31:0] PRDATA1, PRDATA2;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL1     (PSEL1),
        .PSEL2     (PSEL2),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PREADY1   (PREADY1),
        .PREADY2   (PREADY2),
        .PRDATA1   (PRDATA1),
        .PRDATA2   (PRDATA2)
    );

    // Slave models: wait_n wait states, byte-strobed memories starting at zero.
    int          wait_n = 4;
    logic        stall1 = 1'b0;
    logic        hi2 = 1'b0;
    int          w1 = 0;
    int          w2 = 0;
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];

    assign PREADY1 = stall1 ? 1'b0 : (PSEL1 && PENABLE && (w1 >= wait_n));
    assign PREADY2 = hi2 ? 1'b1 : (PSEL2 && PENABLE && (w2 >= wait_n));
    assign PRDATA1 = mem1[PADDR];
    assign PRDATA2 = mem2[PADDR];

    always @(posedge PCLK) begin
        w1 <= (PSEL1 && PENABLE && !PREADY1) ? w1 + 1 : 0;
        w2 <= (PSEL2 && PENABLE && !PREADY2) ? w2 + 1 : 0;
        for (int b = 0; b < 4; b++) begin
            if (PSEL1 && PENABLE && PREADY1 && PWRITE && PSTRB[b])
                mem1[PADDR][8*b +: 8] <= PWDATA[8*b +: 8];
            if (PSEL2 && PENABLE && PREADY2 && PWRITE && PSTRB[b])
                mem2[PADDR][8*b +: 8] <= PWDATA[8*b +: 8];
        end
    end

    // Monitors: cycle count, acceptance log, response pulses, PSEL2 activity.
    int   cyc = 0;
    int   rsp_cnt = 0;
    int   acc_log [$];
    logic psel2_seen = 1'b0;
    logic psel2_clr = 1'b0;

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (PRESETn && cmd_valid && cmd_ready) acc_log.push_back(cyc);
        if (psel2_clr) psel2_seen <= 1'b0;
        else if (PSEL2) psel2_seen <= 1'b1;
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, wait (bounded) for its response, return read data and error.
    task automatic xfer(input string tag, input logic wr, input logic [8:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin step(); n++; end
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 60) begin step(); n++; end
        chk({tag, "_done"}, rsp_valid, 1'b1);
        rd = rsp_rdata;
        er = rsp_err;
        step();
    endtask

    logic [31:0] rd;
    logic        er;
    int          r0;

    initial begin
        for (int i = 0; i < 256; i++) begin mem1[i] = '0; mem2[i] = '0; end

        // Reset state
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_psel", {PSEL1, PSEL2, PENABLE, PWRITE, rsp_err}, 5'b0);
        chk("rst_paddr", PADDR, 8'h00);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_pstrb", PSTRB, 4'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        PRESETn = 1'b1;
        step();
        chk("post_rst_ready", cmd_ready, 1'b1);

        // Write slave 2, W=4, exact timing
        wait_n = 4;
        cmd_write = 1'b1; cmd_addr = 9'h105; cmd_wdata = 32'hDEADBEEF; cmd_strb = 4'b0101;
        cmd_valid = 1'b1;
        step();                                   // edge 0
        cmd_valid = 1'b0;
        chk("w2_setup_ready", cmd_ready, 1'b0);
        chk("w2_setup_sel", {PSEL1, PSEL2, PENABLE, PWRITE}, 4'b0101);
        chk("w2_setup_paddr", PADDR, 8'h05);
        chk("w2_setup_pstrb", PSTRB, 4'b0101);
        chk("w2_setup_pwdata", PWDATA, 32'hDEADBEEF);
        step();                                   // edge 1
        chk("w2_access_sel", {PSEL1, PSEL2, PENABLE, PWRITE}, 4'b0111);
        chk("w2_access_pstrb", PSTRB, 4'b0101);
        step(); step(); step(); step();           // edges 2..5
        chk("w2_e5_rsp", rsp_valid, 1'b0);
        chk("w2_e5_hold", {PSEL2, PENABLE, PADDR}, {2'b11, 8'h05});
        step();                                   // edge 6
        chk("w2_e6_rsp", rsp_valid, 1'b1);
        chk("w2_e6_rdata", rsp_rdata, 32'h0);
        chk("w2_e6_ready", cmd_ready, 1'b1);
        chk("w2_e6_drop", {PSEL1, PSEL2, PENABLE, rsp_err}, 4'b0);
        step();
        chk("w2_e7_rsp", rsp_valid, 1'b0);

        // Write slave 1 then read it back; PSEL2 must stay low on the read
        xfer("w1", 1'b1, 9'h005, 32'h12345678, 4'hF, rd, er);
        psel2_clr = 1'b1; step(); psel2_clr = 1'b0;
        cmd_write = 1'b0; cmd_addr = 9'h005; cmd_wdata = 32'hFFFFFFFF; cmd_strb = 4'hF;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("r1_setup_pstrb", PSTRB, 4'h0);
        chk("r1_setup_sel", {PSEL1, PSEL2, PENABLE, PWRITE}, 4'b1000);
        r0 = 0;
        while (!rsp_valid && r0 < 60) begin step(); r0++; end
        chk("r1_latency", r0, 6);
        chk("r1_rdata", rsp_rdata, 32'h12345678);
        chk("r1_no_psel2", psel2_seen, 1'b0);

        // Read slave 2 back: strobes 0101 over zeroed memory
        xfer("r2", 1'b0, 9'h105, 32'h0, 4'h0, rd, er);
        chk("r2_rdata", rd, 32'h00AD00EF);
        chk("r2_err", er, 1'b0);

        // Zero-wait back-to-back, cmd_valid held across three writes
        wait_n = 0;
        acc_log.delete();
        r0 = rsp_cnt;
        cmd_write = 1'b1; cmd_addr = 9'h020; cmd_wdata = 32'hA0A0A0A0; cmd_strb = 4'hF;
        cmd_valid = 1'b1;
        step();                                   // edge 0
        cmd_addr = 9'h021; cmd_wdata = 32'hB1B1B1B1;
        step(); step();                           // edges 1,2
        chk("b2b_rsp1", {rsp_valid, cmd_ready}, 2'b11);
        step();                                   // edge 3
        cmd_addr = 9'h022; cmd_wdata = 32'hC2C2C2C2;
        step(); step(); step();                   // edges 4..6
        cmd_valid = 1'b0;
        step(); step(); step(); step();
        chk("b2b_acc_count", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            chk("b2b_gap1", acc_log[1] - acc_log[0], 3);
            chk("b2b_gap2", acc_log[2] - acc_log[1], 3);
        end
        chk("b2b_rsp_count", rsp_cnt - r0, 3);
        chk("b2b_mem", {mem1[8'h20], mem1[8'h22]}, {32'hA0A0A0A0, 32'hC2C2C2C2});

        // Unselected PREADY2 high while slave 1 stalls
        wait_n = 2;
        stall1 = 1'b1; hi2 = 1'b1;
        r0 = rsp_cnt;
        cmd_write = 1'b0; cmd_addr = 9'h005; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("unsel_no_rsp", rsp_cnt - r0, 0);
        chk("unsel_in_access", {PSEL1, PSEL2, PENABLE}, 3'b101);
        stall1 = 1'b0; hi2 = 1'b0;
        r0 = 0;
        while (!rsp_valid && r0 < 20) begin step(); r0++; end
        chk("unsel_done", rsp_valid, 1'b1);
        chk("unsel_rdata", rsp_rdata, 32'h12345678);
        step();

`ifdef APB_TIMEOUT_EN
        // Stuck PREADY: error completion after 16 ACCESS cycles
        stall1 = 1'b1;
        cmd_write = 1'b0; cmd_addr = 9'h005; cmd_valid = 1'b1;
        step();                                   // edge 0
        cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) step();      // edges 1..16
        chk("to_e16_rsp", rsp_valid, 1'b0);
        step();                                   // edge 17
        chk("to_e17_rsp", {rsp_valid, rsp_err}, 2'b11);
        chk("to_rdata", rsp_rdata, 32'h0);
        chk("to_drop", {PSEL1, PENABLE}, 2'b00);
        stall1 = 1'b0;
        step();
        xfer("to_next", 1'b0, 9'h005, 32'h0, 4'h0, rd, er);
        chk("to_next_err", er, 1'b0);
        chk("to_next_rdata", rd, 32'h12345678);
`endif

        // Async reset mid-ACCESS: everything drops, no response
        stall1 = 1'b1;
        cmd_write = 1'b1; cmd_addr = 9'h00A; cmd_wdata = 32'h55AA55AA; cmd_strb = 4'hF;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step(); step();
        r0 = rsp_cnt;
        #2 PRESETn = 1'b0;
        #1;
        chk("arst_outputs", {cmd_ready, rsp_valid, PSEL1, PSEL2, PENABLE, PWRITE}, 6'b0);
        chk("arst_bus", {PADDR, PWDATA, PSTRB}, 44'h0);
        stall1 = 1'b0;
        step(); step();
        chk("arst_no_rsp", rsp_cnt - r0, 0);
        PRESETn = 1'b1;
        chk("arst_ready_low", cmd_ready, 1'b0);
        step();
        chk("arst_ready_back", cmd_ready, 1'b1);
        chk("arst_mem_untouched", mem1[8'h0A], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
